// File: rtl/gest_ctrl_pipe.sv
// Two-stage hand-gesture control pipeline: clamps both hand positions, quantises
// hover/roll/pitch into buckets and arms/disarms the outputs on a held corner gesture.
module gest_ctrl_pipe #(
  parameter int COORD_W       = 16,
  parameter int MAX_X         = 650,
  parameter int MAX_Y         = 460,
  parameter int MIN_Z         = 550,
  parameter int MAX_Z         = 1300,
  parameter int NUM_BUCKETS   = 4,
  parameter int EDGE_X        = 100,
  parameter int EDGE_Y        = 80,
  parameter int HOLD_SAMPLES  = 8,
  parameter int ROLL_DEADBAND = 40
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sample_valid,
  input  logic [COORD_W-1:0] left_x,
  input  logic [COORD_W-1:0] left_y,
  input  logic [COORD_W-1:0] left_z,
  input  logic [COORD_W-1:0] right_x,
  input  logic [COORD_W-1:0] right_y,
  input  logic [COORD_W-1:0] right_z,
  output logic               out_valid,
  output logic [7:0]         hover,
  output logic [7:0]         roll,
  output logic [7:0]         pitch,
  output logic [1:0]         roll_direction,
  output logic               on,
  output logic               track_lost,
  output logic [1:0]         gest_state
);

  localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [COORD_W-1:0] MAX_X_C    = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] MAX_Y_C    = COORD_W'(MAX_Y);
  localparam logic [COORD_W-1:0] MIN_Z_C    = COORD_W'(MIN_Z);
  localparam logic [COORD_W-1:0] MAX_Z_C    = COORD_W'(MAX_Z);
  localparam logic [COORD_W-1:0] EDGE_X_C   = COORD_W'(EDGE_X);
  localparam logic [COORD_W-1:0] EDGE_Y_C   = COORD_W'(EDGE_Y);
  localparam logic [COORD_W:0]   MAX_Y_W    = (COORD_W+1)'(MAX_Y);
  localparam logic [COORD_W:0]   MIN_Z_W    = (COORD_W+1)'(MIN_Z);
  localparam logic [COORD_W:0]   DEADBAND_W = (COORD_W+1)'(ROLL_DEADBAND);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, LATCHED = 2'd2} state_e;

  function automatic logic [COORD_W-1:0] clamp_hi(input logic [COORD_W-1:0] v,
                                                  input logic [COORD_W-1:0] hi);
    return (v > hi) ? hi : v;
  endfunction

  function automatic logic [COORD_W-1:0] clamp_rng(input logic [COORD_W-1:0] v,
                                                   input logic [COORD_W-1:0] lo,
                                                   input logic [COORD_W-1:0] hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Thresholds fold to constants: k, range and NUM_BUCKETS are all static.
  function automatic logic [7:0] bucket(input logic [COORD_W:0] v, input int range);
    logic [7:0] b;
    b = '0;
    for (int k = 1; k < 16; k++)
      if (k < NUM_BUCKETS && int'(v) >= (k * range) / NUM_BUCKETS) b = b + 8'd1;
    return b;
  endfunction

  logic [COORD_W-1:0]      lx_c, ly_c, lz_c, rx_c, ry_c, rz_c;
  logic                    lost_l, lost_r, qual;
  logic [COORD_W:0]        sum_y_c, sum_z_c;
  logic signed [COORD_W:0] d_c;

  // Stage 0: clamp, lost detection, gesture qualification
  always_comb begin
    lx_c    = clamp_hi(left_x, MAX_X_C);
    rx_c    = clamp_hi(right_x, MAX_X_C);
    ly_c    = clamp_hi(left_y, MAX_Y_C);
    ry_c    = clamp_hi(right_y, MAX_Y_C);
    lz_c    = clamp_rng(left_z, MIN_Z_C, MAX_Z_C);
    rz_c    = clamp_rng(right_z, MIN_Z_C, MAX_Z_C);
    lost_l  = (left_x == '0) && (left_y == '0);
    lost_r  = (right_x == '0) && (right_y == '0);
    qual    = !lost_l && !lost_r && (lx_c < EDGE_X_C) && (rx_c > (MAX_X_C - EDGE_X_C)) &&
              (ly_c < EDGE_Y_C) && (ry_c < EDGE_Y_C);
    sum_y_c = {1'b0, ly_c} + {1'b0, ry_c};
    sum_z_c = {1'b0, lz_c} + {1'b0, rz_c};
    d_c     = $signed({1'b0, ry_c}) - $signed({1'b0, ly_c});
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             on_q, on_d;

  // Toggle FSM steps with the incoming sample so a completed hold reaches stage 2 with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    on_d    = on_q;
    if (sample_valid) begin
      case (state_q)
        IDLE: if (qual) begin
          if (HOLD_SAMPLES <= 1) begin
            on_d    = !on_q;
            state_d = LATCHED;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = HOLD;
          end
        end
        HOLD: if (qual) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (int'(cnt_d) >= HOLD_SAMPLES) begin
            on_d    = !on_q;
            state_d = LATCHED;
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
        LATCHED: if (!qual) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
    end
  end

  logic [COORD_W:0]        sum_y_p1, sum_z_p1;
  logic signed [COORD_W:0] d_p1;
  logic                    lost_p1;

  // Stage 1: sums and signed roll difference
  always_ff @(posedge clock) begin
    if (sample_valid) begin
      sum_y_p1 <= sum_y_c;
      sum_z_p1 <= sum_z_c;
      d_p1     <= d_c;
      lost_p1  <= lost_l | lost_r;
    end
  end

  logic [COORD_W:0] hov_v, pit_v, absd;
  logic [7:0]       hover_d, roll_d, pitch_d;
  logic [1:0]       dir_d;

  always_comb begin
    hov_v   = MAX_Y_W - (sum_y_p1 >> 1);
    pit_v   = (sum_z_p1 >> 1) - MIN_Z_W;
    absd    = d_p1[COORD_W] ? unsigned'(-d_p1) : unsigned'(d_p1);
    hover_d = bucket(hov_v, MAX_Y);
    pitch_d = bucket(pit_v, MAX_Z - MIN_Z);
    roll_d  = '0;
    dir_d   = 2'd0;
    if (absd >= DEADBAND_W) begin
      roll_d = bucket(absd, MAX_Y);
      dir_d  = d_p1[COORD_W] ? 2'd1 : 2'd2;
    end
    if (lost_p1 || !on_q) begin
      hover_d = '0;
      roll_d  = '0;
      pitch_d = '0;
      dir_d   = 2'd0;
    end
  end

  logic       vld_p1_q, out_valid_q, on_p2_q, lost_p2_q;
  logic [7:0] hover_p2_q, roll_p2_q, pitch_p2_q;
  logic [1:0] dir_p2_q;

  // Stage 2: registered control outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      on_p2_q     <= 1'b0;
      lost_p2_q   <= 1'b0;
      hover_p2_q  <= '0;
      roll_p2_q   <= '0;
      pitch_p2_q  <= '0;
      dir_p2_q    <= 2'd0;
    end else begin
      vld_p1_q    <= sample_valid;
      out_valid_q <= vld_p1_q;
      if (vld_p1_q) begin
        on_p2_q    <= on_q;
        lost_p2_q  <= lost_p1;
        hover_p2_q <= hover_d;
        roll_p2_q  <= roll_d;
        pitch_p2_q <= pitch_d;
        dir_p2_q   <= dir_d;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign hover          = hover_p2_q;
  assign roll           = roll_p2_q;
  assign pitch          = pitch_p2_q;
  assign roll_direction = dir_p2_q;
  assign on             = on_p2_q;
  assign track_lost     = lost_p2_q;
  assign gest_state     = state_q;

endmodule
